// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver and its storage: state encoding,
// maze geometry and the wall/free bit values.
package maze_pkg;

  localparam int MAZE_WIDTH = 6;
  localparam int MAZE_CELLS = 1 << (2 * MAZE_WIDTH);

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } maze_state_e;

  // Row-major flat index of a cell.
  function automatic logic [2*MAZE_WIDTH-1:0] cell_index(
    input logic [MAZE_WIDTH-1:0] row,
    input logic [MAZE_WIDTH-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/maze_bitplane.sv
// One-bit-wide cell memory: a synchronous write port, an enabled read port
// whose output holds between reads, and a free-running read port.
module maze_bitplane
  import maze_pkg::*;
#(
  parameter int   AW    = 12,
  parameter logic A_RST = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic          i_a_en,
  input  logic [AW-1:0] i_a_addr,
  output logic          o_a_data,
  input  logic [AW-1:0] i_b_addr,
  output logic          o_b_data
);

  logic r_mem [0:(1<<AW)-1];
  logic r_a_data;
  logic r_b_data;

  // Contents are deliberately not reset; they are rewritten by a full load.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read registers sample the array before this edge's write lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_data <= A_RST;
      r_b_data <= FREE;
    end else begin
      if (i_a_en) begin
        r_a_data <= r_mem[i_a_addr];
      end
      r_b_data <= r_mem[i_b_addr];
    end
  end

  assign o_a_data = r_a_data;
  assign o_b_data = r_b_data;

endmodule

// File: rtl/maze_mem.sv
// Maze storage behind the wall-follower solver: serial wall-plane load,
// solver read/mark access, sticky mark-on-wall flag and a debug read port.
module maze_mem
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_valid,
  input  logic                  i_load_data,
  output logic                  o_load_ready,
  output logic                  o_load_done,
  input  logic [maze_width-1:0] i_row,
  input  logic [maze_width-1:0] i_col,
  input  logic                  i_maze_oe,
  input  logic                  i_maze_we,
  output logic                  o_maze_in,
  output logic                  o_we_on_wall,
  input  logic [maze_width-1:0] i_dbg_row,
  input  logic [maze_width-1:0] i_dbg_col,
  output logic                  o_dbg_wall,
  output logic                  o_dbg_path
);

  localparam int AW = 2 * maze_width;

  maze_state_e   r_state;
  logic [AW-1:0] r_cnt;
  logic          r_load_ready;
  logic          r_load_done;
  logic          r_oe_d;
  logic          r_we_d;
  logic          r_maze_hold;
  logic          r_we_on_wall;

  logic          w_run;
  logic          w_accept;
  logic          w_probe_en;
  logic          w_path_we;
  logic [AW-1:0] w_path_addr;
  logic          w_path_wdata;
  logic [AW-1:0] w_solver_addr;
  logic [AW-1:0] w_dbg_addr;
  logic          w_wall_a;
  logic          w_path_unused_a;

  assign w_run         = (r_state == ST_RUN);
  assign w_accept      = i_load_valid & (r_state == ST_LOAD);
  assign w_probe_en    = w_run & (i_maze_oe | i_maze_we);
  assign w_solver_addr = {i_row, i_col};
  assign w_dbg_addr    = {i_dbg_row, i_dbg_col};

  // Path plane is cleared cell by cell during load and marked during solve.
  always_comb begin
    w_path_we    = 1'b0;
    w_path_addr  = r_cnt;
    w_path_wdata = 1'b0;
    if (w_run) begin
      w_path_we    = i_maze_we;
      w_path_addr  = w_solver_addr;
      w_path_wdata = 1'b1;
    end else begin
      w_path_we    = w_accept;
      w_path_addr  = r_cnt;
      w_path_wdata = 1'b0;
    end
  end

  // Load/run sequencing with the handshake outputs kept in registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_LOAD;
      r_cnt        <= {AW{1'b0}};
      r_load_ready <= 1'b1;
      r_load_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
            if (&r_cnt) begin
              r_state      <= ST_RUN;
              r_load_ready <= 1'b0;
              r_load_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_load_ready <= 1'b0;
          r_load_done  <= 1'b1;
        end
        default: begin
          r_state      <= ST_LOAD;
          r_cnt        <= {AW{1'b0}};
          r_load_ready <= 1'b1;
          r_load_done  <= 1'b0;
        end
      endcase
    end
  end

  // The wall port also probes on marks, so maze_in keeps its own held copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oe_d       <= 1'b0;
      r_we_d       <= 1'b0;
      r_maze_hold  <= WALL;
      r_we_on_wall <= 1'b0;
    end else begin
      r_oe_d      <= w_run & i_maze_oe;
      r_we_d      <= w_run & i_maze_we;
      r_maze_hold <= o_maze_in;
      if (r_we_d && (w_wall_a == WALL)) begin
        r_we_on_wall <= 1'b1;
      end
    end
  end

  maze_bitplane #(.AW(AW), .A_RST(WALL)) u_wall (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_accept),
    .i_waddr  (r_cnt),
    .i_wdata  (i_load_data),
    .i_a_en   (w_probe_en),
    .i_a_addr (w_solver_addr),
    .o_a_data (w_wall_a),
    .i_b_addr (w_dbg_addr),
    .o_b_data (o_dbg_wall)
  );

  maze_bitplane #(.AW(AW), .A_RST(FREE)) u_path (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_path_we),
    .i_waddr  (w_path_addr),
    .i_wdata  (w_path_wdata),
    .i_a_en   (1'b0),
    .i_a_addr (w_solver_addr),
    .o_a_data (w_path_unused_a),
    .i_b_addr (w_dbg_addr),
    .o_b_data (o_dbg_path)
  );

  assign o_maze_in    = r_oe_d ? w_wall_a : r_maze_hold;
  assign o_we_on_wall = r_we_on_wall;
  assign o_load_ready = r_load_ready;
  assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_maze_mem.sv
// Directed bench for maze_mem: expected wall/path/maze_in bits come from a
// bench-side wall model and are queued at stimulus time, popped at sampling.
module tb_maze_mem;

  localparam int W    = 6;
  localparam int SIDE = 1 << W;
  localparam int N    = SIDE * SIDE;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_data;
  logic         load_ready;
  logic         load_done;
  logic [W-1:0] row;
  logic [W-1:0] col;
  logic         maze_oe;
  logic         maze_we;
  logic         maze_in;
  logic         we_on_wall;
  logic [W-1:0] dbg_row;
  logic [W-1:0] dbg_col;
  logic         dbg_wall;
  logic         dbg_path;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  maze_mem #(.maze_width(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .o_load_done  (load_done),
    .i_row        (row),
    .i_col        (col),
    .i_maze_oe    (maze_oe),
    .i_maze_we    (maze_we),
    .o_maze_in    (maze_in),
    .o_we_on_wall (we_on_wall),
    .i_dbg_row    (dbg_row),
    .i_dbg_col    (dbg_col),
    .o_dbg_wall   (dbg_wall),
    .o_dbg_path   (dbg_path)
  );

  function automatic logic is_wall(input int r, input int c);
    return (r == 0) || (r == SIDE - 1) || (c == 0) || (c == SIDE - 1) ||
           ((r == 10) && (c == 11));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic dbg_read(input int r, input int c, input logic ew, input logic ep);
    dbg_row = W'(r);
    dbg_col = W'(c);
    exp_q.push_back(ew);
    exp_q.push_back(ep);
    tick();
    sb_check("dbg_wall", dbg_wall);
    sb_check("dbg_path", dbg_path);
  endtask

  task automatic solver_read(input int r, input int c);
    row     = W'(r);
    col     = W'(c);
    maze_oe = 1'b1;
    exp_q.push_back(is_wall(r, c));
    tick();
    maze_oe = 1'b0;
    sb_check("maze_in", maze_in);
  endtask

  task automatic mark(input int r, input int c);
    row     = W'(r);
    col     = W'(c);
    maze_we = 1'b1;
    tick();
    maze_we = 1'b0;
  endtask

  // Streams n cells of the model maze with random bubbles.
  task automatic load(input int n, input bit watch_done);
    int  acc = 0;
    int  cyc = 0;
    logic v;
    while ((acc < n) && (cyc < 8 * N)) begin
      v          = ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data  = is_wall(acc / SIDE, acc % SIDE);
      if (v && watch_done && (acc == N - 1)) begin
        check("load_done_before_last", load_done, 1'b0);
        check("load_ready_before_last", load_ready, 1'b1);
      end
      tick();
      if (v) acc++;
      if (v && watch_done && (acc == N)) begin
        check("load_done_at_last", load_done, 1'b1);
        check("load_ready_at_last", load_ready, 1'b0);
      end
      cyc++;
    end
    load_valid = 1'b0;
    if (acc < n) begin
      checks++;
      errors++;
      $error("FAIL load_timeout observed=%0d expected=%0d", acc, n);
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 1'b0;
    row        = '0;
    col        = '0;
    maze_oe    = 1'b0;
    maze_we    = 1'b0;
    dbg_row    = '0;
    dbg_col    = '0;

    tick();
    tick();
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_maze_in", maze_in, 1'b1);
    check("rst_we_on_wall", we_on_wall, 1'b0);
    check("rst_dbg_wall", dbg_wall, 1'b0);
    check("rst_dbg_path", dbg_path, 1'b0);
    rst = 1'b0;

    // premature solver access while still loading
    row     = W'(5);
    col     = W'(5);
    maze_oe = 1'b1;
    maze_we = 1'b1;
    tick();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    check("preload_maze_in", maze_in, 1'b1);
    check("preload_load_ready", load_ready, 1'b1);
    check("preload_load_done", load_done, 1'b0);
    tick();
    check("preload_we_on_wall", we_on_wall, 1'b0);

    load(N, 1'b1);

    // host data offered in RUN must not touch the wall plane
    load_valid = 1'b1;
    load_data  = 1'b0;
    tick();
    tick();
    tick();
    load_valid = 1'b0;
    check("run_load_ready", load_ready, 1'b0);
    check("run_load_done", load_done, 1'b1);

    dbg_read(10, 11, 1'b1, 1'b0);
    dbg_read(10, 12, 1'b0, 1'b0);
    dbg_read(0, 0, 1'b1, 1'b0);
    dbg_read(0, 1, 1'b1, 1'b0);
    dbg_read(SIDE - 1, SIDE - 1, 1'b1, 1'b0);

    solver_read(10, 11);
    solver_read(10, 12);
    tick();
    tick();
    tick();
    check("maze_in_hold", maze_in, 1'b0);

    // mark (20,20) while debug watches it: old bit first, new bit next cycle
    dbg_row = W'(20);
    dbg_col = W'(20);
    exp_q.push_back(1'b0);
    mark(20, 20);
    sb_check("dbg_path_old", dbg_path);
    exp_q.push_back(1'b1);
    tick();
    sb_check("dbg_path_new", dbg_path);
    check("clean_mark_we_on_wall", we_on_wall, 1'b0);

    // read and mark in the same cycle
    row     = W'(20);
    col     = W'(21);
    maze_oe = 1'b1;
    maze_we = 1'b1;
    exp_q.push_back(is_wall(20, 21));
    tick();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    sb_check("oe_we_maze_in", maze_in);
    dbg_read(20, 21, 1'b0, 1'b1);

    // mark on a border wall: sticky flag, maze_in unaffected
    mark(0, 7);
    tick();
    check("wall_mark_we_on_wall", we_on_wall, 1'b1);
    check("wall_mark_maze_in_hold", maze_in, 1'b0);
    mark(30, 30);
    tick();
    check("sticky_we_on_wall", we_on_wall, 1'b1);
    dbg_read(0, 7, 1'b1, 1'b1);
    solver_read(0, 7);

    // reset mid-solve, partial reload, reset again, full reload
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("resolve_rst_load_done", load_done, 1'b0);
    check("resolve_rst_load_ready", load_ready, 1'b1);
    check("resolve_rst_we_on_wall", we_on_wall, 1'b0);
    check("resolve_rst_maze_in", maze_in, 1'b1);
    load(1000, 1'b0);
    check("partial_load_done", load_done, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midload_rst_load_ready", load_ready, 1'b1);
    load(N, 1'b1);

    dbg_read(10, 11, 1'b1, 1'b0);
    dbg_read(10, 12, 1'b0, 1'b0);
    dbg_read(0, 5, 1'b1, 1'b0);
    dbg_read(5, 0, 1'b1, 1'b0);
    dbg_read(20, 20, 1'b0, 1'b0);
    dbg_read(20, 21, 1'b0, 1'b0);
    dbg_read(0, 7, 1'b1, 1'b0);
    dbg_read(30, 30, 1'b0, 1'b0);
    solver_read(10, 11);
    solver_read(33, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_mem.md
# maze_mem

Maze storage stage sitting directly downstream of the wall-follower solver: consumes its `row`/`col`/`maze_oe`/`maze_we` requests and produces the `maze_in` wall bit it reads. Holds a 2^maze_width × 2^maze_width wall plane, loaded serially from a host before solving, and a path plane recording every cell the solver marks. A registered debug port exposes both planes for path readback and checking.

## Interface
- `maze_width`, 6, coordinate width; maze is 2^maze_width square (64×64 default)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `load_valid`  in  1  host offers one wall bit
- `load_data`  in  1  wall bit (1 = wall, 0 = free), row-major order
- `load_ready`  out  1  block accepts a wall bit this cycle
- `load_done`  out  1  full maze loaded; solver access enabled
- `row`, `col`  in  maze_width  solver cell address
- `maze_oe`  in  1  solver read request
- `maze_we`  in  1  solver mark request (sets path bit)
- `maze_in`  out  1  wall bit of last read cell
- `we_on_wall`  out  1  sticky: a mark hit a wall cell
- `dbg_row`, `dbg_col`  in  maze_width  debug address
- `dbg_wall`, `dbg_path`  out  1  registered wall/path bits at debug address

## Operation
- States: LOAD, RUN. Reset → LOAD.
- LOAD: `load_ready`=1. Each cycle with `load_valid & load_ready` writes `load_data` to wall[idx] and clears path[idx], idx = row-major counter (2·maze_width bits, row = idx[MSBs], col = idx[LSBs]). On acceptance of the last cell (idx = all-ones) counter wraps to 0, state → RUN.
- RUN: `load_ready`=0, `load_done`=1; `load_valid` ignored. Stays in RUN until `rst`.
- Read: `maze_oe` in RUN registers wall[row][col] into `maze_in`; `maze_in` holds its value until the next accepted read.
- Mark: `maze_we` in RUN sets path[row][col]. If wall[row][col]=1, path bit is still set and `we_on_wall` sets (sticky until `rst`).
- `maze_oe` and `maze_we` same cycle: both performed; read returns the wall bit, unaffected by the mark.
- `maze_oe`/`maze_we` during LOAD: ignored; `maze_in` forced 1 (wall) so a premature solver never walks.
- Debug port active in every state; reads do not disturb solver or load paths.
- All addresses in range by construction (full 2^maze_width decode); no bounds checking.

## Timing
- Reset values: `load_ready`=1 (LOAD entered same edge), `load_done`=0, `maze_in`=1, `we_on_wall`=0, `dbg_wall`=0, `dbg_path`=0, counter=0. Memory contents not reset; path cleared only by reload.
- Read latency 1: `maze_oe` sampled at edge t → `maze_in` valid after edge t, i.e. usable by the solver in its next state.
- Mark effective at edge t; a debug or solver read at edge t sees the old path bit, at t+1 the new one.
- Load: 4096 cells (default) need exactly 4096 accepted handshakes; `load_done` rises at the edge accepting the last cell. Bubbles (`load_valid`=0) stall without loss.
- Debug latency 1: `dbg_*` sampled at edge t, outputs valid after t.
- `rst` mid-load or mid-solve: next edge returns to LOAD, counter 0, flags cleared; host must reload the whole maze.

## Structure
- Shared package: state encoding (LOAD, RUN) and `MAZE_CELLS = 1 << (2*maze_width)`, wall/free bit constants (WALL=1, FREE=0), shared with the solver.
- One sub-module `maze_bitplane`: 1-bit × MAZE_CELLS memory with one synchronous write port and two registered read ports; instantiated twice (wall, path). Top holds FSM, load counter, port muxing, `we_on_wall`.

## Test plan
- Reset then `maze_oe`=1 at (5,5) before load → `maze_in`=1, `load_ready`=1, `load_done`=0.
- Stream 4096 bits, wall only on border and at (10,11), with random `load_valid` bubbles → `load_done` rises on the 4096th accept; debug read (10,11) → `dbg_wall`=1, (10,12) → 0.
- RUN: `maze_oe` at (10,11) edge t → `maze_in`=1 after t; `maze_oe` at (10,12) t+1 → `maze_in`=0 after t+1, held while `maze_oe`=0.
- `maze_we` at (20,20) → next-cycle debug `dbg_path`=1; same-cycle `maze_oe`+`maze_we` at (20,21) → `maze_in`=0, path set.
- `maze_we` at border cell (0,7) → `we_on_wall`=1 and stays 1 through further clean marks.
- Assert `rst` after 1000 load accepts, reload full maze → counter restarts at (0,0), previously marked path bits read 0.
